// File: rtl/implication_writer.sv
// rtl/implication_writer.sv - implication FIFO, variable assignment table, conflict detection and trail events
// Lookups read the registered table; all updates happen at the clock edge.
module implication_writer #(
  parameter int NUM_VARIABLE   = 128,
  parameter int VAR_W          = $clog2(NUM_VARIABLE),
  parameter int VAR_PER_CLAUSE = 5,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              imp_valid,
  output logic                              imp_ready,
  input  logic [VAR_W-1:0]                  imp_variable,
  input  logic                              imp_value,
  input  logic                              decide_valid,
  output logic                              decide_ready,
  input  logic [VAR_W-1:0]                  decide_variable,
  input  logic                              decide_value,
  input  logic                              stall,
  input  logic                              unassign_valid,
  input  logic [VAR_W-1:0]                  unassign_variable,
  input  logic                              clear,
  input  logic                              conflict_ack,
  input  logic [VAR_PER_CLAUSE*VAR_W-1:0]   lk_variable,
  output logic [VAR_PER_CLAUSE-1:0]         lk_unassign,
  output logic [VAR_PER_CLAUSE-1:0]         lk_assignment,
  output logic                              assign_valid,
  output logic [VAR_W-1:0]                  assign_variable,
  output logic                              assign_value,
  output logic                              assign_is_decision,
  output logic                              conflict,
  output logic [VAR_W-1:0]                  conflict_variable,
  output logic                              fifo_empty,
  output logic [VAR_W:0]                    num_assigned
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ST_RUN = 1'b0, ST_CONFLICT = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [NUM_VARIABLE-1:0] r_assigned;
  logic [NUM_VARIABLE-1:0] r_value;
  logic [VAR_W:0]          r_num_assigned;

  logic [VAR_W-1:0]      r_fifo_var [FIFO_DEPTH];
  logic                  r_fifo_val [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic                  r_assign_valid;
  logic [VAR_W-1:0]      r_assign_variable;
  logic                  r_assign_value;
  logic                  r_assign_is_decision;
  logic                  r_conflict;
  logic [VAR_W-1:0]      r_conflict_variable;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_decide;
  logic                  w_apply;
  logic [VAR_W-1:0]      w_apply_var;
  logic                  w_apply_val;
  logic                  w_apply_ok;
  logic                  w_cur_assigned;
  logic                  w_cur_value;
  logic                  w_unassign_ok;
  logic                  w_unassign_hit;
  logic                  w_unassign_dec;
  logic                  w_new_assign;
  logic                  w_conflict_hit;
  logic [VAR_W-1:0]      w_lk_var;

  // Index 0 is the "no variable" marker and never lives in the table.
  function automatic logic f_var_ok(input logic [VAR_W-1:0] v);
    return (v != '0) && (int'(v) < NUM_VARIABLE);
  endfunction

  assign w_push   = imp_valid && imp_ready && !clear;
  assign w_decide = decide_valid && decide_ready && !clear;
  assign w_pop    = (r_state == ST_RUN) && !stall && (r_count != '0) && !clear;

  // A decision needs an empty FIFO, so it can never collide with a pop.
  assign w_apply     = w_pop || w_decide;
  assign w_apply_var = w_pop ? r_fifo_var[r_rd_ptr] : decide_variable;
  assign w_apply_val = w_pop ? r_fifo_val[r_rd_ptr] : decide_value;
  assign w_apply_ok  = w_apply && f_var_ok(w_apply_var);

  assign w_cur_assigned = r_assigned[w_apply_var];
  assign w_cur_value    = r_value[w_apply_var];

  assign w_unassign_ok  = unassign_valid && f_var_ok(unassign_variable) && !clear;
  assign w_unassign_hit = w_unassign_ok && (unassign_variable == w_apply_var);
  assign w_unassign_dec = w_unassign_ok && r_assigned[unassign_variable];

  assign w_new_assign   = w_apply_ok && !w_cur_assigned && !w_unassign_hit;
  assign w_conflict_hit = w_apply_ok && w_cur_assigned && (w_cur_value != w_apply_val) && !w_unassign_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:      if (w_conflict_hit) w_state_next = ST_CONFLICT;
        ST_CONFLICT: if (conflict_ack)   w_state_next = ST_RUN;
        default:     w_state_next = ST_RUN;
      endcase
    end
  end

  always_comb begin
    imp_ready    = (r_state == ST_RUN) && (r_count < CNT_W'(FIFO_DEPTH));
    decide_ready = (r_state == ST_RUN) && (r_count == '0) && !imp_valid && !stall;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_var[r_wr_ptr] <= imp_variable;
      r_fifo_val[r_wr_ptr] <= imp_value;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_assigned           <= '0;
      r_value              <= '0;
      r_num_assigned       <= '0;
      r_wr_ptr             <= '0;
      r_rd_ptr             <= '0;
      r_count              <= '0;
      r_assign_valid       <= 1'b0;
      r_assign_variable    <= '0;
      r_assign_value       <= 1'b0;
      r_assign_is_decision <= 1'b0;
      r_conflict           <= 1'b0;
      r_conflict_variable  <= '0;
    end else begin
      r_assign_valid <= w_new_assign;
      if (w_new_assign) begin
        r_assign_variable    <= w_apply_var;
        r_assign_value       <= w_apply_val;
        r_assign_is_decision <= w_decide;
        r_assigned[w_apply_var] <= 1'b1;
        r_value[w_apply_var]    <= w_apply_val;
      end
      if (w_unassign_ok) begin
        r_assigned[unassign_variable] <= 1'b0;
        r_value[unassign_variable]    <= 1'b0;
      end
      r_num_assigned <= r_num_assigned + (VAR_W+1)'(w_new_assign) - (VAR_W+1)'(w_unassign_dec);

      if (w_conflict_hit) begin
        r_conflict          <= 1'b1;
        r_conflict_variable <= w_apply_var;
      end else if ((r_state == ST_CONFLICT) && conflict_ack) begin
        r_conflict <= 1'b0;
      end

      // A conflict flushes the queue, including anything pushed on that edge.
      if (w_conflict_hit) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

  always_comb begin
    lk_unassign   = '1;
    lk_assignment = '0;
    w_lk_var      = '0;
    for (int i = 0; i < VAR_PER_CLAUSE; i++) begin
      w_lk_var = lk_variable[i*VAR_W +: VAR_W];
      if (f_var_ok(w_lk_var)) begin
        lk_unassign[i]   = !r_assigned[w_lk_var];
        lk_assignment[i] = r_assigned[w_lk_var] & r_value[w_lk_var];
      end
    end
  end

  assign assign_valid       = r_assign_valid;
  assign assign_variable    = r_assign_variable;
  assign assign_value       = r_assign_value;
  assign assign_is_decision = r_assign_is_decision;
  assign conflict           = r_conflict;
  assign conflict_variable  = r_conflict_variable;
  assign fifo_empty         = (r_count == '0);
  assign num_assigned       = r_num_assigned;

endmodule

// File: tb/tb_implication_writer.sv
// tb/tb_implication_writer.sv - scoreboard bench for implication_writer
module tb_implication_writer;

  localparam int VW = 7;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              imp_valid, imp_ready, imp_value;
  logic [VW-1:0]     imp_variable;
  logic              decide_valid, decide_ready, decide_value;
  logic [VW-1:0]     decide_variable;
  logic              stall, unassign_valid, clear, conflict_ack;
  logic [VW-1:0]     unassign_variable;
  logic [5*VW-1:0]   lk_variable;
  logic [4:0]        lk_unassign, lk_assignment;
  logic              assign_valid, assign_value, assign_is_decision;
  logic [VW-1:0]     assign_variable;
  logic              conflict, fifo_empty;
  logic [VW-1:0]     conflict_variable;
  logic [VW:0]       num_assigned;

  typedef struct {
    logic [VW-1:0] v;
    logic          val;
    logic          dec;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  implication_writer dut (
    .clk(clk), .rst_n(rst_n),
    .imp_valid(imp_valid), .imp_ready(imp_ready), .imp_variable(imp_variable), .imp_value(imp_value),
    .decide_valid(decide_valid), .decide_ready(decide_ready),
    .decide_variable(decide_variable), .decide_value(decide_value),
    .stall(stall), .unassign_valid(unassign_valid), .unassign_variable(unassign_variable),
    .clear(clear), .conflict_ack(conflict_ack), .lk_variable(lk_variable),
    .lk_unassign(lk_unassign), .lk_assignment(lk_assignment),
    .assign_valid(assign_valid), .assign_variable(assign_variable), .assign_value(assign_value),
    .assign_is_decision(assign_is_decision), .conflict(conflict), .conflict_variable(conflict_variable),
    .fifo_empty(fifo_empty), .num_assigned(num_assigned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [VW-1:0] v, input logic b);
    imp_variable = v;
    imp_value    = b;
    imp_valid    = 1'b1;
    step(1);
    imp_valid    = 1'b0;
  endtask

  function automatic ev_t mk(input logic [VW-1:0] v, input logic val, input logic dec);
    ev_t e;
    e.v = v; e.val = val; e.dec = dec;
    return e;
  endfunction

  // Monitor: every trail event must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && assign_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: got var=%0d val=%0d dec=%0d expected none",
                 assign_variable, assign_value, assign_is_decision);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("event_var", 32'(assign_variable), 32'(e.v));
        chk("event_val", 32'(assign_value), 32'(e.val));
        chk("event_dec", 32'(assign_is_decision), 32'(e.dec));
      end
    end
  end

  initial begin
    int n_ev;
    int first_i;
    int last_i;

    rst_n = 1'b0;
    imp_valid = 0; imp_variable = '0; imp_value = 0;
    decide_valid = 0; decide_variable = '0; decide_value = 0;
    stall = 0; unassign_valid = 0; unassign_variable = '0;
    clear = 0; conflict_ack = 0;
    lk_variable = {7'd1, 7'd0, 7'd3, 7'd7, 7'd5};
    step(3);
    rst_n = 1'b1;

    chk("rst_imp_ready", 32'(imp_ready), 32'd1);
    chk("rst_fifo_empty", 32'(fifo_empty), 32'd1);
    chk("rst_lk_unassign", 32'(lk_unassign), 32'h1f);
    chk("rst_num_assigned", 32'(num_assigned), 32'd0);
    chk("rst_conflict", 32'(conflict), 32'd0);
    chk("rst_assign_valid", 32'(assign_valid), 32'd0);

    // single implication
    exp_q.push_back(mk(7'd5, 1'b1, 1'b0));
    push(7'd5, 1'b1);
    step(3);
    chk("v5_unassign", 32'(lk_unassign[0]), 32'd0);
    chk("v5_assignment", 32'(lk_assignment[0]), 32'd1);
    chk("v5_num_assigned", 32'(num_assigned), 32'd1);

    // duplicate, then conflicting value; third push lands on the conflict edge and is flushed
    push(7'd5, 1'b1);
    push(7'd5, 1'b0);
    push(7'd9, 1'b1);
    step(2);
    chk("cf_conflict", 32'(conflict), 32'd1);
    chk("cf_variable", 32'(conflict_variable), 32'd5);
    chk("cf_imp_ready", 32'(imp_ready), 32'd0);
    chk("cf_decide_ready", 32'(decide_ready), 32'd0);
    chk("cf_fifo_empty", 32'(fifo_empty), 32'd1);
    chk("cf_num_assigned", 32'(num_assigned), 32'd1);
    conflict_ack = 1'b1;
    step(1);
    conflict_ack = 1'b0;
    chk("ack_conflict", 32'(conflict), 32'd0);
    chk("ack_imp_ready", 32'(imp_ready), 32'd1);
    step(3);

    unassign_variable = 7'd5;
    unassign_valid = 1'b1;
    step(1);
    unassign_valid = 1'b0;
    chk("unassign5_num", 32'(num_assigned), 32'd0);
    chk("unassign5_lk", 32'(lk_unassign[0]), 32'd1);

    // fill under stall, 9th push refused, then drain back-to-back
    stall = 1'b1;
    for (int v = 1; v <= 8; v++) begin
      exp_q.push_back(mk(VW'(v), v[0], 1'b0));
      push(VW'(v), v[0]);
    end
    chk("full_imp_ready", 32'(imp_ready), 32'd0);
    push(7'd9, 1'b1);
    chk("full_still_not_ready", 32'(imp_ready), 32'd0);
    chk("full_not_empty", 32'(fifo_empty), 32'd0);
    stall = 1'b0;
    n_ev = 0; first_i = -1; last_i = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (assign_valid) begin
        n_ev++;
        if (first_i < 0) first_i = i;
        last_i = i;
      end
    end
    #1;
    chk("drain_pulses", 32'(n_ev), 32'd8);
    chk("drain_consecutive", 32'(last_i - first_i), 32'd7);
    chk("drain_num_assigned", 32'(num_assigned), 32'd8);
    chk("drain_empty", 32'(fifo_empty), 32'd1);
    chk("drain_lk_unassign", 32'(lk_unassign), 32'h08);
    chk("drain_lk_assignment", 32'(lk_assignment), 32'h17);

    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clr_num_assigned", 32'(num_assigned), 32'd0);
    chk("clr_lk_unassign", 32'(lk_unassign), 32'h1f);

    // variable 0 is dropped; decision waits for a quiet port
    imp_variable = 7'd0; imp_value = 1'b1; imp_valid = 1'b1;
    #1;
    chk("dec_blocked_by_imp", 32'(decide_ready), 32'd0);
    @(posedge clk); #1;
    imp_valid = 1'b0;
    step(2);
    decide_variable = 7'd7; decide_value = 1'b0; decide_valid = 1'b1;
    #1;
    chk("dec_ready", 32'(decide_ready), 32'd1);
    exp_q.push_back(mk(7'd7, 1'b0, 1'b1));
    @(posedge clk); #1;
    decide_valid = 1'b0;
    step(2);
    chk("dec_num_assigned", 32'(num_assigned), 32'd1);
    chk("dec_lk_unassign", 32'(lk_unassign), 32'h1d);
    chk("dec_lk_assignment", 32'(lk_assignment), 32'h00);

    // clear with queued entries
    stall = 1'b1;
    push(7'd10, 1'b1);
    push(7'd11, 1'b0);
    push(7'd12, 1'b1);
    chk("q3_not_empty", 32'(fifo_empty), 32'd0);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("q3_clr_empty", 32'(fifo_empty), 32'd1);
    chk("q3_clr_num", 32'(num_assigned), 32'd0);
    chk("q3_clr_no_event", 32'(assign_valid), 32'd0);
    stall = 1'b0;
    step(4);

    // unassign racing an apply of the same variable
    decide_variable = 7'd3; decide_value = 1'b1; decide_valid = 1'b1;
    unassign_variable = 7'd3; unassign_valid = 1'b1;
    step(1);
    decide_valid = 1'b0; unassign_valid = 1'b0;
    step(2);
    chk("race_v3_unassign", 32'(lk_unassign[2]), 32'd1);
    chk("race_num_assigned", 32'(num_assigned), 32'd0);

    step(2);
    chk("events_outstanding", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
